// File: rtl/snake_pkg.sv
// Shared types and sizing helpers for the snake-order feature-map feeder.
package snake_pkg;

  typedef enum logic [1:0] {IDLE, HEAD, SNAKE, DRAIN} state_t;

  localparam int PIX_DW = 32;

  typedef struct packed {
    logic [PIX_DW-1:0] data;
    logic              last;
    logic              is_pad;
  } pixel_t;

  // Counters must reach ROWS+1 / COLS+1 when the zero border is enabled.
  function automatic int row_w(input int rows);
    return (rows + 2 > 2) ? $clog2(rows + 2) : 1;
  endfunction

  function automatic int col_w(input int cols);
    return (cols + 2 > 2) ? $clog2(cols + 2) : 1;
  endfunction

endpackage

// File: rtl/snake_skid_buf.sv
// Two-entry valid/ready buffer behind the SRAM read; an empty buffer passes the in-flight beat straight through.
// room is high while at most one beat is held or in flight, so a new read issued now always has a slot.
module snake_skid_buf
  import snake_pkg::*;
#(
  parameter type pix_t = pixel_t
) (
  input  logic clk,
  input  logic rst,
  input  logic in_vld,
  input  pix_t in_dat,
  output logic room,
  output logic out_vld,
  output pix_t out_dat,
  input  logic out_rdy
);

  logic [1:0] cnt;
  pix_t       ent0;
  pix_t       ent1;
  logic       push;
  logic       pop;

  assign pop     = (cnt != 2'd0) && out_rdy;
  assign push    = in_vld && !((cnt == 2'd0) && out_rdy);
  assign room    = (cnt == 2'd0) || ((cnt == 2'd1) && !in_vld);
  assign out_vld = (cnt != 2'd0) || in_vld;

  always_comb begin
    out_dat = '0;
    if (cnt != 2'd0) out_dat = ent0;
    else if (in_vld) out_dat = in_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= 2'd0;
      ent0 <= '0;
      ent1 <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (cnt == 2'd0) ent0 <= in_dat;
          else             ent1 <= in_dat;
          cnt <= cnt + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          cnt  <= cnt - 2'd1;
        end
        2'b11: begin
          if (cnt == 2'd1) begin
            ent0 <= in_dat;
          end else begin
            ent0 <= ent1;
            ent1 <= in_dat;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/snake_scan_feeder.sv
// Streams a CH_IN-channel feature map from SRAM to the PE array in snake order, optional 1-pixel zero border.
// Start to first out_valid is 2 cycles, 1 pixel/clk; issue pauses whenever the skid buffer could overflow.
module snake_scan_feeder
  import snake_pkg::*;
#(
  parameter int ROWS    = 128,
  parameter int COLS    = 128,
  parameter int CH_IN   = 4,
  parameter int PEA_NUM = 32,
  parameter int ADDR_W  = 14
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 pad_en,
  output logic                 mem_rd_en,
  output logic [ADDR_W-1:0]    mem_addr,
  input  logic [CH_IN*8-1:0]   mem_rd_data,
  output logic [PEA_NUM*8-1:0] out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last,
  output logic                 busy,
  output logic                 done
);

  localparam int ROW_W = row_w(ROWS);
  localparam int COL_W = col_w(COLS);
  localparam int DW    = CH_IN * 8;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
    logic          is_pad;
  } pix_t;

  state_t            state, state_n;
  logic [ROW_W-1:0]  r, r_n, vr_m1;
  logic [COL_W-1:0]  c, c_n, vc_m1;
  logic [ADDR_W-1:0] base, base_n;
  logic              pad, pad_n;
  logic              done_q, done_n;
  logic              room, issue, issue_pad, issue_last, at_row_end;
  logic              infl_vld, infl_pad, infl_last;
  pix_t              infl_dat, head_dat;
  logic              head_vld;

  assign vr_m1      = pad ? ROW_W'(ROWS + 1) : ROW_W'(ROWS - 1);
  assign vc_m1      = pad ? COL_W'(COLS + 1) : COL_W'(COLS - 1);
  assign issue_pad  = pad && (r == '0 || r == vr_m1 || c == '0 || c == vc_m1);
  // r[0] is the walk direction: odd rows run left-to-right, even rows right-to-left.
  assign at_row_end = r[0] ? (c == vc_m1) : (c == '0);

  always_comb begin
    state_n    = state;
    r_n        = r;
    c_n        = c;
    base_n     = base;
    pad_n      = pad;
    done_n     = 1'b0;
    issue      = 1'b0;
    issue_last = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && !done_q) begin
          state_n = HEAD;
          pad_n   = pad_en;
          r_n     = '0;
          c_n     = '0;
          // base tracks (r-pad)*COLS; the border row's negative base is never used for a read.
          base_n  = pad_en ? (ADDR_W'(0) - ADDR_W'(COLS)) : '0;
        end
      end
      HEAD: begin
        if (room) begin
          issue = 1'b1;
          if (!r[0]) begin
            r_n    = ROW_W'(1);
            base_n = base + ADDR_W'(COLS);
          end else if (c == vc_m1) begin
            if (r == vr_m1) begin
              issue_last = 1'b1;
              state_n    = DRAIN;
            end else begin
              state_n = SNAKE;
              r_n     = r + ROW_W'(1);
              base_n  = base + ADDR_W'(COLS);
            end
          end else begin
            r_n    = '0;
            c_n    = c + COL_W'(1);
            base_n = base - ADDR_W'(COLS);
          end
        end
      end
      SNAKE: begin
        if (room) begin
          issue = 1'b1;
          if (at_row_end) begin
            if (r == vr_m1) begin
              issue_last = 1'b1;
              state_n    = DRAIN;
            end else begin
              r_n    = r + ROW_W'(1);
              base_n = base + ADDR_W'(COLS);
            end
          end else if (r[0]) begin
            c_n = c + COL_W'(1);
          end else begin
            c_n = c - COL_W'(1);
          end
        end
      end
      DRAIN: begin
        if (out_valid && out_ready && out_last) begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      r         <= '0;
      c         <= '0;
      base      <= '0;
      pad       <= 1'b0;
      done_q    <= 1'b0;
      infl_vld  <= 1'b0;
      infl_pad  <= 1'b0;
      infl_last <= 1'b0;
    end else begin
      state     <= state_n;
      r         <= r_n;
      c         <= c_n;
      base      <= base_n;
      pad       <= pad_n;
      done_q    <= done_n;
      infl_vld  <= issue;
      infl_pad  <= issue_pad;
      infl_last <= issue_last;
    end
  end

  assign mem_rd_en = issue && !issue_pad;
  assign mem_addr  = mem_rd_en ? (base + ADDR_W'(c) - ADDR_W'(pad)) : '0;

  always_comb begin
    infl_dat        = '0;
    infl_dat.data   = infl_pad ? '0 : mem_rd_data;
    infl_dat.last   = infl_last;
    infl_dat.is_pad = infl_pad;
  end

  snake_skid_buf #(
    .pix_t(pix_t)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .in_vld (infl_vld),
    .in_dat (infl_dat),
    .room   (room),
    .out_vld(head_vld),
    .out_dat(head_dat),
    .out_rdy(out_ready)
  );

  always_comb begin
    out_data         = '0;
    out_data[DW-1:0] = head_dat.data & {DW{~head_dat.is_pad}};
  end

  assign out_valid = head_vld;
  assign out_last  = head_dat.last;
  assign busy      = (state != IDLE);
  assign done      = done_q;

endmodule

// File: tb/tb_snake_scan_feeder.sv
// Randomized frames on three map sizes, checked against a coordinate-list model of the snake order.
`timescale 1ns/1ps
module tb_snake_scan_feeder;

  localparam int NI = 3;
  localparam int RS [NI] = '{4, 2, 3};
  localparam int CS [NI] = '{3, 2, 2};
  localparam int AW = 14;
  localparam int OW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, pad_en, out_ready;
  int   sel;

  logic          en_v   [NI];
  logic [AW-1:0] addr_v [NI];
  logic [OW-1:0] od_v   [NI];
  logic          vld_v  [NI];
  logic          last_v [NI];
  logic          busy_v [NI];
  logic          done_v [NI];
  logic [31:0]   mem    [16];

  int n_cmp, n_bad;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [31:0] rd;
    always @(posedge clk) rd <= en_v[g] ? mem[addr_v[g][3:0]] : 32'hDEAD_BEEF;

    snake_scan_feeder #(
      .ROWS(RS[g]), .COLS(CS[g]), .CH_IN(4), .PEA_NUM(32), .ADDR_W(AW)
    ) u_dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start && (sel == g)),
      .pad_en     (pad_en),
      .mem_rd_en  (en_v[g]),
      .mem_addr   (addr_v[g]),
      .mem_rd_data(rd),
      .out_data   (od_v[g]),
      .out_valid  (vld_v[g]),
      .out_ready  (out_ready),
      .out_last   (last_v[g]),
      .busy       (busy_v[g]),
      .done       (done_v[g])
    );
  end

  logic m_en, m_vld, m_last, m_busy, m_done;
  logic [AW-1:0] m_addr;
  logic [OW-1:0] m_dat;
  always_comb begin
    m_en   = en_v[sel];
    m_addr = addr_v[sel];
    m_dat  = od_v[sel];
    m_vld  = vld_v[sel];
    m_last = last_v[sel];
    m_busy = busy_v[sel];
    m_done = done_v[sel];
  end

  task automatic check(input string tag, input logic [287:0] got, input logic [287:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [31:0] exp_dat[$];
  bit          exp_last[$];
  int          exp_addr[$];

  // Enumerate virtual coordinates in stream order, then map each to a word or a zero border pixel.
  task automatic build(input int s, input bit pad);
    int vr, vc, a;
    int rr[$];
    int cc[$];
    bit is_pad;
    vr = RS[s] + 2 * int'(pad);
    vc = CS[s] + 2 * int'(pad);
    exp_dat.delete(); exp_last.delete(); exp_addr.delete();
    for (int c = 0; c < vc; c++) begin
      rr.push_back(0); cc.push_back(c);
      rr.push_back(1); cc.push_back(c);
    end
    for (int r = 2; r < vr; r++)
      for (int k = 0; k < vc; k++) begin
        rr.push_back(r);
        cc.push_back((r % 2 == 0) ? vc - 1 - k : k);
      end
    for (int i = 0; i < rr.size(); i++) begin
      is_pad = pad && (rr[i] == 0 || rr[i] == vr - 1 || cc[i] == 0 || cc[i] == vc - 1);
      if (is_pad) begin
        exp_dat.push_back(32'h0);
      end else begin
        a = (rr[i] - int'(pad)) * CS[s] + cc[i] - int'(pad);
        exp_addr.push_back(a);
        exp_dat.push_back(mem[a]);
      end
      exp_last.push_back(i == rr.size() - 1);
    end
  endtask

  // ev: 0 plain, 1 start again at beat 5, 2 reset at beat 6, 3 start in the done cycle
  task automatic run_frame(input int s, input bit pad, input int rmode, input int ev);
    int nbeat, nrd, ndone, first_vld, last_cyc, done_cyc;
    bit fin, prev_stall, prev_last, restarted;
    logic [OW-1:0] prev_dat;
    nbeat = 0; nrd = 0; ndone = 0; first_vld = -1; last_cyc = -1; done_cyc = -1;
    fin = 0; prev_stall = 0; prev_last = 0; restarted = 0; prev_dat = '0;
    build(s, pad);
    for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
      @(negedge clk);
      sel    = s;
      start  = (cyc == 0) || (ev == 1 && nbeat == 5 && !restarted) ||
               (ev == 3 && last_cyc >= 0 && cyc == last_cyc + 1);
      if (ev == 1 && nbeat == 5) restarted = 1;
      pad_en = (cyc == 0) ? pad : 1'($urandom_range(0, 1));
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (ev == 2 && nbeat == 6) begin
        rst = 1'b1; start = 1'b0;
        #1;
        check("rst_async", {m_en, m_vld, m_last, m_busy, m_done, m_addr, m_dat}, '0);
        @(negedge clk);
        rst = 1'b0;
        fin = 1;
        continue;
      end
      #1;
      if (m_en) begin
        if (nrd < exp_addr.size()) check("rd_addr", m_addr, exp_addr[nrd]);
        nrd++;
      end
      if (prev_stall) check("stall_hold", {m_vld, m_last, m_dat}, {1'b1, prev_last, prev_dat});
      if (m_vld && first_vld < 0) first_vld = cyc;
      if (m_vld && out_ready) begin
        if (nbeat < exp_dat.size()) begin
          check("beat_dat", m_dat, {224'b0, exp_dat[nbeat]});
          check("beat_last", m_last, exp_last[nbeat]);
        end
        if (m_last) last_cyc = cyc;
        nbeat++;
      end
      prev_stall = m_vld && !out_ready;
      prev_dat   = m_dat;
      prev_last  = m_last;
      if (m_done) begin
        ndone++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (cyc == 1) check("busy_run", m_busy, 1'b1);
      if (done_cyc >= 0 && cyc >= done_cyc + 3) fin = 1;
    end
    @(negedge clk);
    start = 1'b0;
    if (ev == 2) return;
    check("frame_end", fin, 1'b1);
    check("beats", nbeat, exp_dat.size());
    check("reads", nrd, exp_addr.size());
    check("done_cnt", ndone, 1);
    check("done_lat", done_cyc - last_cyc, 1);
    check("first_lat", first_vld, 2);
    check("busy_end", m_busy, 1'b0);
  endtask

  task automatic rand_mem();
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1'b1; start = 1'b0; pad_en = 1'b0; out_ready = 1'b0; sel = 0;
    rand_mem();
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      sel = i;
      #1;
      check("reset_out", {m_en, m_vld, m_last, m_busy, m_done, m_addr, m_dat}, '0);
    end
    @(negedge clk);
    rst = 1'b0;

    mem[0] = 32'hDDCCBBAA;
    run_frame(0, 1'b0, 0, 0);
    rand_mem(); run_frame(1, 1'b1, 0, 0);
    rand_mem(); run_frame(0, 1'b0, 1, 0);
    rand_mem(); run_frame(0, 1'b1, 2, 0);
    rand_mem(); run_frame(2, 1'b0, 2, 0);
    rand_mem(); run_frame(2, 1'b1, 1, 0);
    rand_mem(); run_frame(1, 1'b0, 2, 0);
    rand_mem(); run_frame(0, 1'b0, 2, 1);
    rand_mem(); run_frame(0, 1'b1, 0, 3);
    rand_mem(); run_frame(0, 1'b0, 1, 2);
    run_frame(0, 1'b0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      rand_mem();
      run_frame($urandom_range(0, NI - 1), 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
